// File: rtl/stopwatch_key_conditioner.sv
// Purpose : turns the raw start/stop and hold push-buttons into clean debounced levels and 1-cycle command strobes.
// Latency : a clean raw edge shows on keys_debounced/strobes DEBOUNCE_CYCLES+2 clock edges later, counting the edge that first samples it.
// Backpr. : none; strobes are fire-and-forget and must be consumed in the single cycle they are high.
module stopwatch_key_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int LONG_PRESS_CYCLES = 75_000_000,
    parameter bit KEY_ACTIVE_LOW    = 1'b1
) (
    input  logic       CLK_50,
    input  logic       reset_n,
    input  logic       key_start_stop,
    input  logic       key_hold,
    output logic       start_stop_pulse,
    output logic       clear_pulse,
    output logic       hold_pulse,
    output logic [1:0] keys_debounced
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    // Internally bit 1 = hold, bit 0 = start/stop, and 1 always means pressed.
    logic [1:0]         pressed;
    logic [1:0]         s1;
    logic [1:0]         s2;
    logic [1:0]         deb;
    logic [1:0]         deb_nxt;
    logic [1:0][DW-1:0] cnt;
    logic [1:0][DW-1:0] cnt_nxt;
    logic [1:0]         deb_rise;
    logic [1:0]         deb_fall;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PW-1:0]      pc;
    logic [PW-1:0]      pc_nxt;
    logic [PW-1:0]      pc_inc;
    logic               ss_nxt;
    logic               clr_nxt;

    assign pressed        = {key_hold, key_start_stop} ^ {2{KEY_ACTIVE_LOW}};
    assign keys_debounced = deb;
    assign deb_rise       = deb_nxt & ~deb;
    assign deb_fall       = ~deb_nxt & deb;
    assign pc_inc         = pc + 1'b1;

    // Two-flop synchroniser on the polarity-normalised keys
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pressed;
            s2 <= s1;
        end
    end

    // Debounce: accept a new level only after it differs from deb for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2[i] != deb[i]) begin
                if (cnt[i] == DEB_LAST) begin
                    deb_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels and their stability counters
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            deb <= deb_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Start/stop press classifier; acts on the debounced edge so strobes line up with the level change
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ss_nxt    = 1'b0;
        clr_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (deb_rise[0]) begin
                    state_nxt = ST_PRESSED;
                    pc_nxt    = '0;
                end
            end
            ST_PRESSED: begin
                // Release wins over the limit when both land on the same edge
                if (deb_fall[0]) begin
                    ss_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    pc_nxt = pc_inc;
                    if (pc_inc == PC_LAST) begin
                        clr_nxt   = 1'b1;
                        state_nxt = ST_LONG;
                    end
                end
            end
            ST_LONG: begin
                if (deb_fall[0]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Classifier state and press-duration counter
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Registered command strobes
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            start_stop_pulse <= 1'b0;
            clear_pulse      <= 1'b0;
            hold_pulse       <= 1'b0;
        end else begin
            start_stop_pulse <= ss_nxt;
            clear_pulse      <= clr_nxt;
            hold_pulse       <= deb_rise[1];
        end
    end

endmodule

// File: tb/tb_stopwatch_key_conditioner.sv
// Purpose : self-checking bench for stopwatch_key_conditioner with a behavioural key model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_stopwatch_key_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       k_ss   = 1'b1;
    logic       k_hold = 1'b1;
    logic       ss_p;
    logic       clr_p;
    logic       hold_p;
    logic [1:0] kd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_key_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .KEY_ACTIVE_LOW   (1'b1)
    ) dut (
        .CLK_50          (clk),
        .reset_n         (rst_n),
        .key_start_stop  (k_ss),
        .key_hold        (k_hold),
        .start_stop_pulse(ss_p),
        .clear_pulse     (clr_p),
        .hold_pulse      (hold_p),
        .keys_debounced  (kd)
    );

    // Reference model: a key level is accepted once the last DEB samples seen
    // through the 2-cycle synchroniser all disagree with the current level.
    // A press is short if released before it has lasted LONG-1 clocks past acceptance.
    bit [DEB+1:0] h_ss;
    bit [DEB+1:0] h_hd;
    bit m_deb_ss, m_deb_hd, m_ss, m_clr, m_hold;
    bit new_ss, new_hd;
    bit p_active, p_cleared;
    int p_len;

    function automatic bit all_differ(input bit [DEB+1:0] h, input bit level);
        for (int i = 2; i <= DEB + 1; i++) begin
            if (h[i] == level) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_ss = '0; h_hd = '0;
            m_deb_ss = 0; m_deb_hd = 0; m_ss = 0; m_clr = 0; m_hold = 0;
            p_active = 0; p_cleared = 0; p_len = 0;
        end else begin
            h_ss = {h_ss[DEB:0], ~k_ss};
            h_hd = {h_hd[DEB:0], ~k_hold};
            new_ss = all_differ(h_ss, m_deb_ss) ? ~m_deb_ss : m_deb_ss;
            new_hd = all_differ(h_hd, m_deb_hd) ? ~m_deb_hd : m_deb_hd;
            m_hold = new_hd & ~m_deb_hd;
            m_ss = 0;
            m_clr = 0;
            if (new_ss && !m_deb_ss) begin
                p_active = 1; p_len = 0; p_cleared = 0;
            end else if (!new_ss && m_deb_ss) begin
                if (p_active && !p_cleared) m_ss = 1;
                p_active = 0;
            end else if (p_active && new_ss) begin
                p_len++;
                if (p_len == LONG - 1 && !p_cleared) begin
                    m_clr = 1; p_cleared = 1;
                end
            end
            m_deb_ss = new_ss;
            m_deb_hd = new_hd;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; k_ss = 1'b1; k_hold = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d dut=%b want=00000", e, {kd, ss_p, clr_p, hold_p});
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d dut=%b want=00000", e, {kd, ss_p, clr_p, hold_p});
            end
        end
    endtask

    task automatic test_short_press();
        int t_rise = -1, t_fall = -1, t_ss = -1, n_ss = 0, n_clr = 0;
        logic [1:0] kd_prev;
        kd_prev = kd;
        for (int e = 1; e <= 30; e++) begin
            k_ss = (e <= 12) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL short_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (kd[0] && !kd_prev[0]) t_rise = e;
            if (!kd[0] && kd_prev[0]) t_fall = e;
            if (ss_p) begin n_ss++; t_ss = e; end
            if (clr_p) n_clr++;
            kd_prev = kd;
        end
        checks++;
        if (t_rise != 6) begin errors++; $display("FAIL short_rise got=%0d want=6", t_rise); end
        checks++;
        if (t_fall != 18) begin errors++; $display("FAIL short_fall got=%0d want=18", t_fall); end
        checks++;
        if (n_ss != 1 || t_ss != 18) begin
            errors++; $display("FAIL short_ss count=%0d at=%0d want=1 at 18", n_ss, t_ss);
        end
        checks++;
        if (n_clr != 0) begin errors++; $display("FAIL short_clr count=%0d want=0", n_clr); end
    endtask

    task automatic test_bounce();
        int t_hold = -1, n_hold = 0, early = 0;
        for (int e = 1; e <= 45; e++) begin
            if (e <= 20) k_hold = (((e - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else         k_hold = (e <= 32) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (e < 26 && kd[1]) early++;
            if (hold_p) begin n_hold++; t_hold = e; end
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL bounce_level early_cycles=%0d want=0", early); end
        checks++;
        if (n_hold != 1 || t_hold != 26) begin
            errors++; $display("FAIL bounce_pulse count=%0d at=%0d want=1 at 26", n_hold, t_hold);
        end
    endtask

    task automatic test_long_press();
        int t_rise = -1, t_fall = -1, t_clr = -1, n_ss = 0, n_clr = 0;
        logic [1:0] kd_prev;
        kd_prev = kd;
        for (int e = 1; e <= 55; e++) begin
            k_ss = (e <= 40) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL long_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (kd[0] && !kd_prev[0]) t_rise = e;
            if (!kd[0] && kd_prev[0]) t_fall = e;
            if (clr_p) begin n_clr++; t_clr = e; end
            if (ss_p) n_ss++;
            kd_prev = kd;
        end
        checks++;
        if (n_clr != 1 || t_clr - t_rise != 15) begin
            errors++; $display("FAIL long_clr count=%0d delay=%0d want=1 delay 15", n_clr, t_clr - t_rise);
        end
        checks++;
        if (n_ss != 0) begin errors++; $display("FAIL long_ss count=%0d want=0", n_ss); end
        checks++;
        if (t_fall != 46) begin errors++; $display("FAIL long_fall got=%0d want=46", t_fall); end
    endtask

    task automatic test_limit_boundary(input int low_len, input bit expect_short);
        int t_rise = -1, t_fall = -1, n_ss = 0, n_clr = 0;
        logic [1:0] kd_prev;
        kd_prev = kd;
        for (int e = 1; e <= 35; e++) begin
            k_ss = (e <= low_len) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL limit_model len=%0d cyc=%0d dut=%b model=%b", low_len, e,
                         {kd, ss_p, clr_p, hold_p}, {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (kd[0] && !kd_prev[0]) t_rise = e;
            if (!kd[0] && kd_prev[0]) t_fall = e;
            if (ss_p) n_ss++;
            if (clr_p) n_clr++;
            kd_prev = kd;
        end
        checks++;
        if (t_fall - t_rise != low_len) begin
            errors++; $display("FAIL limit_span len=%0d got=%0d want=%0d", low_len, t_fall - t_rise, low_len);
        end
        checks++;
        if (n_ss != (expect_short ? 1 : 0) || n_clr != (expect_short ? 0 : 1)) begin
            errors++;
            $display("FAIL limit_class len=%0d ss=%0d clr=%0d want ss=%0d clr=%0d", low_len, n_ss, n_clr,
                     expect_short ? 1 : 0, expect_short ? 0 : 1);
        end
    endtask

    task automatic test_simultaneous();
        int t_r0 = -1, t_r1 = -1, t_hold = -1, t_ss = -1, n_ss = 0, n_hold = 0;
        logic [1:0] kd_prev;
        kd_prev = kd;
        for (int e = 1; e <= 25; e++) begin
            k_ss   = (e <= 10) ? 1'b0 : 1'b1;
            k_hold = (e <= 10) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL simul_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (kd[0] && !kd_prev[0]) t_r0 = e;
            if (kd[1] && !kd_prev[1]) t_r1 = e;
            if (hold_p) begin n_hold++; t_hold = e; end
            if (ss_p) begin n_ss++; t_ss = e; end
            kd_prev = kd;
        end
        checks++;
        if (t_r0 != 6 || t_r1 != 6 || t_hold != 6 || n_hold != 1) begin
            errors++;
            $display("FAIL simul_rise r0=%0d r1=%0d hold=%0d nhold=%0d want all 6, 1 pulse", t_r0, t_r1, t_hold, n_hold);
        end
        checks++;
        if (n_ss != 1 || t_ss != 16) begin
            errors++; $display("FAIL simul_ss count=%0d at=%0d want=1 at 16", n_ss, t_ss);
        end
    endtask

    task automatic test_reset_mid_press();
        int n_strobe = 0, t_rise = -1, n_ss = 0, n_clr = 0;
        logic [1:0] kd_prev;
        // Abort a press that is in progress, release the key while in reset
        for (int e = 1; e <= 10; e++) begin
            k_ss = 1'b0;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL rstp_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({kd, ss_p, clr_p, hold_p} !== 5'b0) begin
            errors++; $display("FAIL rstp_async dut=%b want=00000", {kd, ss_p, clr_p, hold_p});
        end
        k_ss = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL rstp_after cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (ss_p || clr_p || hold_p || kd != 2'b00) n_strobe++;
        end
        checks++;
        if (n_strobe != 0) begin errors++; $display("FAIL rstp_nostrobe cycles=%0d want=0", n_strobe); end

        // Key held low across reset release counts as a fresh press
        for (int e = 1; e <= 12; e++) begin
            k_ss = 1'b0;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({kd, ss_p, clr_p, hold_p} !== 5'b0) begin
            errors++; $display("FAIL rsth_async dut=%b want=00000", {kd, ss_p, clr_p, hold_p});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        kd_prev = kd;
        for (int e = 1; e <= 30; e++) begin
            k_ss = (e <= 12) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL rsth_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            if (kd[0] && !kd_prev[0]) t_rise = e;
            if (ss_p) n_ss++;
            if (clr_p) n_clr++;
            kd_prev = kd;
        end
        checks++;
        if (t_rise != 6) begin errors++; $display("FAIL rsth_rise got=%0d want=6", t_rise); end
        checks++;
        if (n_ss != 1 || n_clr != 0) begin
            errors++; $display("FAIL rsth_strobes ss=%0d clr=%0d want ss=1 clr=0", n_ss, n_clr);
        end
    endtask

    task automatic test_random();
        int left_ss = 0, left_hd = 0, n_long = 0;
        logic prev_ss = 1'b0, prev_clr = 1'b0, prev_hd = 1'b0;
        for (int e = 1; e <= 3040; e++) begin
            if (e > 3000) begin
                k_ss = 1'b1; k_hold = 1'b1; rst_n = 1'b1;
            end else begin
                if (left_ss == 0) begin
                    k_ss = 1'($urandom_range(0, 1));
                    left_ss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 30)) : int'($urandom_range(1, 8));
                end else begin
                    left_ss--;
                end
                if (left_hd == 0) begin
                    k_hold = 1'($urandom_range(0, 1));
                    left_hd = int'($urandom_range(1, 12));
                end else begin
                    left_hd--;
                end
                rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            end
            @(negedge clk);
            checks++;
            if ({kd, ss_p, clr_p, hold_p} !== {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold}) begin
                errors++;
                $display("FAIL random_model cyc=%0d dut=%b model=%b", e, {kd, ss_p, clr_p, hold_p},
                         {m_deb_hd, m_deb_ss, m_ss, m_clr, m_hold});
            end
            checks++;
            if ((prev_ss && ss_p) || (prev_clr && clr_p) || (prev_hd && hold_p)) begin
                errors++;
                $display("FAIL random_width cyc=%0d strobes=%b prev=%b", e, {ss_p, clr_p, hold_p},
                         {prev_ss, prev_clr, prev_hd});
            end
            if (m_clr) n_long++;
            prev_ss = ss_p; prev_clr = clr_p; prev_hd = hold_p;
        end
        if (n_long == 0) $display("note: random run produced no long press");
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_bounce();
        test_long_press();
        test_limit_boundary(15, 1'b1);
        test_limit_boundary(16, 1'b0);
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
